writeback_buffer: RTL and testbench

WRITEBACK_BUFFER -- requirements
Module: writeback_buffer

---
 rtl/writeback_buffer.sv | 89 ++++++++
 tb/tb_writeback_buffer.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/writeback_buffer.sv
// writeback_buffer: 2-entry in-order {addr,data} FIFO that feeds a register write port.
// Ports: clk, rst (async active-low); in_valid/in_ready/in_addr/in_data push side;
//   stall, wb_w_enable/wb_addr/wb_data write side; count; rd_addr/fwd_hit/fwd_data bypass.
module writeback_buffer #(
  parameter int N = 8,
  parameter int A = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [A-1:0] in_addr,
  input  logic [N-1:0] in_data,
  input  logic         stall,
  output logic         wb_w_enable,
  output logic [A-1:0] wb_addr,
  output logic [N-1:0] wb_data,
  output logic [1:0]   count,
  input  logic [A-1:0] rd_addr,
  output logic         fwd_hit,
  output logic [N-1:0] fwd_data
);

  logic [1:0][A-1:0] addr_q;
  logic [1:0][N-1:0] data_q;
  logic              head_q;
  logic              tail_q;
  logic [1:0]        cnt_q;

  logic              push;
  logic              pop;
  logic              yng;
  logic              busy;
  logic              full;
  logic              hit_y;
  logic              hit_o;

  assign busy        = (cnt_q != 2'd0);
  assign full        = (cnt_q == 2'd2);
  assign in_ready    = !full;
  assign wb_w_enable = busy && !stall;
  assign push        = in_valid && in_ready;
  assign pop         = wb_w_enable;
  assign count       = cnt_q;

  assign wb_addr = busy ? addr_q[head_q] : '0;
  assign wb_data = busy ? data_q[head_q] : '0;

  // Youngest entry sits just behind tail; the head
  // entry is a distinct second candidate only when full.
  assign yng   = ~tail_q;
  assign hit_y = busy && (addr_q[yng] == rd_addr);
  assign hit_o = full && (addr_q[head_q] == rd_addr);

  always_comb begin
    fwd_hit  = hit_y || hit_o;
    fwd_data = '0;
    if (hit_y) begin
      fwd_data = data_q[yng];
    end else if (hit_o) begin
      fwd_data = data_q[head_q];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q <= '0;
      data_q <= '0;
      head_q <= 1'b0;
      tail_q <= 1'b0;
      cnt_q  <= 2'd0;
    end else begin
      if (push) begin
        addr_q[tail_q] <= in_addr;
        data_q[tail_q] <= in_data;
        tail_q         <= ~tail_q;
      end
      if (pop) begin
        head_q <= ~head_q;
      end
      unique case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_buffer.sv
// tb_writeback_buffer: directed scoreboard bench for writeback_buffer.
// Stimulus queues expected writes; a negedge monitor pops and compares them.
module tb_writeback_buffer;
  localparam int N = 8;
  localparam int A = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [A-1:0] in_addr = '0;
  logic [N-1:0] in_data = '0;
  logic         stall = 1'b0;
  logic         wb_w_enable;
  logic [A-1:0] wb_addr;
  logic [N-1:0] wb_data;
  logic [1:0]   count;
  logic [A-1:0] rd_addr = '0;
  logic         fwd_hit;
  logic [N-1:0] fwd_data;

  typedef struct packed {
    logic [A-1:0] a;
    logic [N-1:0] d;
  } wr_t;

  wr_t sb[$];
  int  n_chk = 0;
  int  n_fail = 0;

  writeback_buffer #(.N(N), .A(A)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_addr(in_addr),
    .in_data(in_data),
    .stall(stall),
    .wb_w_enable(wb_w_enable),
    .wb_addr(wb_addr),
    .wb_data(wb_data),
    .count(count),
    .rd_addr(rd_addr),
    .fwd_hit(fwd_hit),
    .fwd_data(fwd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)",
               nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (wb_w_enable) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0h data %0h, required no write (t=%0t)",
                 wb_addr, wb_data, $time);
      end else begin
        e = sb.pop_front();
        chk("wb_addr", 32'(wb_addr), 32'(e.a));
        chk("wb_data", 32'(wb_data), 32'(e.d));
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic put(input logic [A-1:0] a,
                     input logic [N-1:0] d,
                     input bit expw);
    in_valid = 1'b1;
    in_addr  = a;
    in_data  = d;
    if (expw) sb.push_back(wr_t'{a, d});
  endtask

  initial begin
    #2;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_wen", 32'(wb_w_enable), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_wb_addr", 32'(wb_addr), 0);
    chk("rst_wb_data", 32'(wb_data), 0);
    chk("rst_fwd_hit", 32'(fwd_hit), 0);
    chk("rst_fwd_data", 32'(fwd_data), 0);
    #6 rst = 1'b1;

    // single write
    tick(); put(3'd3, 8'h55, 1);
    smp();  chk("single_nobypass", 32'(wb_w_enable), 0);
    tick(); in_valid = 1'b0;
    smp();  chk("single_count1", 32'(count), 1);
            chk("single_wen", 32'(wb_w_enable), 1);
    tick();
    smp();  chk("single_count0", 32'(count), 0);

    // fill under stall, then full-cycle pop without push
    tick(); stall = 1'b1; put(3'd1, 8'hAA, 1);
    smp();
    tick(); put(3'd2, 8'hBB, 1);
    smp();  chk("fill_count1", 32'(count), 1);
            chk("fill_wen_stall", 32'(wb_w_enable), 0);
    tick(); put(3'd3, 8'hCC, 0);
    smp();  chk("fill_count2", 32'(count), 2);
            chk("fill_ready0", 32'(in_ready), 0);
            chk("fill_wen0", 32'(wb_w_enable), 0);
            chk("fill_head_addr", 32'(wb_addr), 1);
    tick();
    smp();  chk("fill_reject", 32'(count), 2);
            chk("fill_head_data", 32'(wb_data), 32'hAA);
    tick(); stall = 1'b0; sb.push_back(wr_t'{3'd3, 8'hCC});
    smp();  chk("full_pop_ready0", 32'(in_ready), 0);
    tick();
    smp();  chk("after_pop_count", 32'(count), 1);
            chk("after_pop_ready", 32'(in_ready), 1);
    tick(); in_valid = 1'b0;
    smp();  chk("cc_count", 32'(count), 1);
    tick();
    smp();  chk("drain_count0", 32'(count), 0);

    // simultaneous push and pop at count 1
    tick(); put(3'd4, 8'h11, 1);
    smp();
    tick(); put(3'd5, 8'h22, 1);
    smp();  chk("pp_count", 32'(count), 1);
    tick(); in_valid = 1'b0;
    smp();  chk("pp_count_hold", 32'(count), 1);
            chk("pp_head_addr", 32'(wb_addr), 5);
    tick();
    smp();  chk("pp_count0", 32'(count), 0);

    // forwarding
    tick(); stall = 1'b1; rd_addr = 3'd6; put(3'd6, 8'h10, 1);
    smp();  chk("fwd_in_ignored", 32'(fwd_hit), 0);
    tick(); put(3'd6, 8'h20, 1);
    smp();  chk("fwd1_hit", 32'(fwd_hit), 1);
            chk("fwd1_data", 32'(fwd_data), 32'h10);
    tick(); in_valid = 1'b0;
    smp();  chk("fwd2_hit", 32'(fwd_hit), 1);
            chk("fwd2_young", 32'(fwd_data), 32'h20);
    rd_addr = 3'd7;
    #1;     chk("fwd_miss_hit", 32'(fwd_hit), 0);
            chk("fwd_miss_data", 32'(fwd_data), 0);

    // asynchronous reset with two pending entries
    #2;
    rst = 1'b0;
    stall = 1'b0;
    #1;
    chk("mrst_count", 32'(count), 0);
    chk("mrst_wen", 32'(wb_w_enable), 0);
    chk("mrst_ready", 32'(in_ready), 1);
    chk("mrst_wb_data", 32'(wb_data), 0);
    sb.delete();

    // first push accepted at the first edge after release
    tick(); put(3'd2, 8'h77, 1);
    smp();  chk("inrst_count", 32'(count), 0);
    #2 rst = 1'b1;
    tick(); in_valid = 1'b0;
    smp();  chk("first_push", 32'(count), 1);
    tick();
    smp();  chk("first_drain", 32'(count), 0);

    // pointer wrap, back-to-back
    for (int i = 1; i <= 6; i++) begin
      tick(); put(A'(i), N'(i), 1);
      smp();
      chk("wrap_count", 32'(count), (i == 1) ? 0 : 1);
      chk("wrap_wen", 32'(wb_w_enable), (i == 1) ? 0 : 1);
    end
    tick(); in_valid = 1'b0;
    smp();  chk("wrap_last_count", 32'(count), 1);
            chk("wrap_last_wen", 32'(wb_w_enable), 1);
    tick();
    smp();  chk("wrap_count0", 32'(count), 0);

    tick();
    chk("sb_empty", 32'(sb.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
